// File: rtl/timer_host_pkg.sv
// ---------------------------------------------------------------------------
// timer_host_pkg
//
// Shared definitions for the 1 ms interval-timer host:
//   - register indices of the 16-bit Avalon interval timer
//   - host sequencer state encoding
//   - load-value helper (period-1, clamped at 0)
// ---------------------------------------------------------------------------
package timer_host_pkg;

    // Timer slave register map (16-bit words)
    localparam logic [2:0] REG_STATUS   = 3'd0;  // write any value: clear timeout
    localparam logic [2:0] REG_CONTROL  = 3'd1;  // bit0 = ITO
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;  // write: take snapshot, read: low half
    localparam logic [2:0] REG_SNAP_H   = 3'd5;  // read: high half

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_PL,
        ST_CFG_PH,
        ST_CFG_CTL,
        ST_RUN,
        ST_ACK,
        ST_ACK_WAIT,
        ST_SNAP_WR,
        ST_SNAP_RL0,
        ST_SNAP_RL1,
        ST_SNAP_RH0,
        ST_SNAP_RH1
    } state_t;

    // The timer counts from the load value down to zero inclusive, so a
    // period of N cycles needs N-1. A zero period is clamped rather than
    // wrapping to 0xFFFFFFFF.
    function automatic logic [31:0] load_value(input logic [31:0] period);
        return (period == 32'd0) ? 32'd0 : period - 32'd1;
    endfunction

endpackage

// File: rtl/timer_1ms_host.sv
// ---------------------------------------------------------------------------
// timer_1ms_host
//
// Avalon-MM master for the 16-bit-register interval timer that produces the
// 1 ms system tick. Programs period and interrupt enable, services the timer
// interrupt by clearing the timeout flag, counts ticks and reads counter
// snapshots on request. Point-to-point with the timer slave, no arbitration.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   cfg_req, cfg_period pulse: reprogram timer with cfg_period (cycles/tick)
//   snap_req            pulse: take and read a counter snapshot
//   avm_*               Avalon-MM master to the timer (no waitrequest,
//                       readdata registered in the slave, 1-cycle latency)
//   timer_irq           level interrupt from the timer
//   tick                one-cycle pulse per serviced timeout
//   tick_count          serviced timeouts, wraps
//   snapshot            last captured counter value
//   snapshot_valid      one-cycle pulse when snapshot updates
//   configured          high once a full config sequence completed
//   busy                high in every state except RUN and IDLE
// ---------------------------------------------------------------------------
module timer_1ms_host
    import timer_host_pkg::*;
#(
    parameter int unsigned DEFAULT_PERIOD = 50000,
    parameter bit          AUTO_CONFIG    = 1'b1,
    parameter bit          IRQ_ENABLE     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_req,
    input  logic [31:0] cfg_period,
    input  logic        snap_req,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        timer_irq,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic [31:0] snapshot,
    output logic        snapshot_valid,
    output logic        configured,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [31:0] period_q;       // period used by the config sequence in flight
    logic [31:0] pend_period_q;  // latest cfg_period seen with a cfg_req pulse
    logic        cfg_pend_q;
    logic        snap_pend_q;
    logic [15:0] snap_lo_q;
    logic [31:0] load_w;
    logic        take_cfg;       // this cycle starts a config sequence from a request
    logic        take_snap;      // this cycle starts a snapshot sequence
    logic        cfg_any;
    logic        snap_any;

    assign load_w   = load_value(period_q);
    assign cfg_any  = cfg_req  | cfg_pend_q;
    assign snap_any = snap_req | snap_pend_q;
    assign busy     = (state_q != ST_RUN) && (state_q != ST_IDLE);

    // Next state and bus drive. Bus signals decode straight from the state
    // register, so the asynchronous reset releases the bus immediately.
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        avm_address    = REG_STATUS;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = 16'd0;
        take_cfg       = 1'b0;
        take_snap      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (AUTO_CONFIG) begin
                    state_d = ST_CFG_PL;
                end else if (cfg_req) begin
                    state_d  = ST_CFG_PL;
                    take_cfg = 1'b1;
                end
            end
            ST_CFG_PL: begin
                avm_address    = REG_PERIOD_L;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = load_w[15:0];
                state_d        = ST_CFG_PH;
            end
            ST_CFG_PH: begin
                avm_address    = REG_PERIOD_H;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = load_w[31:16];
                state_d        = ST_CFG_CTL;
            end
            ST_CFG_CTL: begin
                avm_address    = REG_CONTROL;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = {15'd0, IRQ_ENABLE};
                state_d        = ST_RUN;
            end
            ST_RUN: begin
                // Priority: timeout service, then reconfigure, then snapshot.
                if (timer_irq) begin
                    state_d = ST_ACK;
                end else if (cfg_any) begin
                    state_d  = ST_CFG_PL;
                    take_cfg = 1'b1;
                end else if (snap_any) begin
                    state_d   = ST_SNAP_WR;
                    take_snap = 1'b1;
                end
            end
            ST_ACK: begin
                avm_address    = REG_STATUS;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                state_d        = ST_ACK_WAIT;
            end
            // Lets the timer drop irq before RUN samples it again.
            ST_ACK_WAIT: state_d = ST_RUN;
            ST_SNAP_WR: begin
                avm_address    = REG_SNAP_L;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                state_d        = ST_SNAP_RL0;
            end
            // Reads: address held for two cycles, data valid in the second.
            ST_SNAP_RL0: begin
                avm_address = REG_SNAP_L;
                state_d     = ST_SNAP_RL1;
            end
            ST_SNAP_RL1: begin
                avm_address = REG_SNAP_L;
                state_d     = ST_SNAP_RH0;
            end
            ST_SNAP_RH0: begin
                avm_address = REG_SNAP_H;
                state_d     = ST_SNAP_RH1;
            end
            ST_SNAP_RH1: begin
                avm_address = REG_SNAP_H;
                state_d     = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture. A pulse that is not consumed in the cycle it arrives
    // is remembered; repeated pulses merge and the newest period wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q      <= 32'(DEFAULT_PERIOD);
            pend_period_q <= 32'd0;
            cfg_pend_q    <= 1'b0;
            snap_pend_q   <= 1'b0;
        end else begin
            if (cfg_req) begin
                pend_period_q <= cfg_period;
            end
            if (take_cfg) begin
                period_q   <= cfg_req ? cfg_period : pend_period_q;
                cfg_pend_q <= 1'b0;
            end else if (cfg_req) begin
                cfg_pend_q <= 1'b1;
            end
            if (take_snap) begin
                snap_pend_q <= 1'b0;
            end else if (snap_req) begin
                snap_pend_q <= 1'b1;
            end
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick           <= 1'b0;
            tick_count     <= 32'd0;
            snapshot       <= 32'd0;
            snapshot_valid <= 1'b0;
            snap_lo_q      <= 16'd0;
            configured     <= 1'b0;
        end else begin
            tick           <= (state_q == ST_ACK);
            snapshot_valid <= (state_q == ST_SNAP_RH1);
            if (state_q == ST_ACK) begin
                tick_count <= tick_count + 32'd1;
            end
            if (state_q == ST_SNAP_RL1) begin
                snap_lo_q <= avm_readdata;
            end
            if (state_q == ST_SNAP_RH1) begin
                snapshot <= {avm_readdata, snap_lo_q};
            end
            if (state_q == ST_CFG_CTL) begin
                configured <= 1'b1;
            end
        end
    end

endmodule

// File: doc/timer_1ms_host.md
Name: timer_1ms_host

Overview:
- Avalon-MM master that drives the 16-bit-register interval timer used for the 1 ms system tick. It acts as the initiator for that timer slave.
- Programs period and interrupt enable, services the timer irq by clearing the timeout flag, and counts ticks.
- Captures the counter snapshot on request.
- Lets FPGA logic use the 1 ms tick without a Nios II driver. Sits beside the timer in the Qsys-generated fabric; point-to-point, no arbitration.

Parameters:
- DEFAULT_PERIOD, 50000: cycles per tick programmed at auto-config. Load value written = DEFAULT_PERIOD-1.
- AUTO_CONFIG, 1: 1 = program timer automatically after reset release; 0 = wait for cfg_req.
- IRQ_ENABLE, 1: value written to control bit0 (ITO).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- cfg_req  in  1  pulse: reprogram timer with cfg_period
- cfg_period  in  32  cycles per tick; sampled when cfg_req is accepted
- snap_req  in  1  pulse: take and read a counter snapshot
- avm_address  out  3  timer register index
- avm_chipselect  out  1  slave select
- avm_write_n  out  1  active-low write strobe
- avm_writedata  out  16  write data
- avm_readdata  in  16  read data, registered in the slave (1-cycle latency)
- timer_irq  in  1  level interrupt from timer
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  32  serviced timeouts, wraps 0xFFFFFFFF->0
- snapshot  out  32  last captured counter value
- snapshot_valid  out  1  one-cycle pulse when snapshot updated
- configured  out  1  high once a full config sequence has completed
- busy  out  1  high in every state except RUN and IDLE

Behaviour:
- Register map (16-bit words):
  - 0 STATUS: write any value clears timeout.
  - 1 CONTROL: bit0 = ITO.
  - 2 PERIOD_L.
  - 3 PERIOD_H.
  - 4 SNAP_L: write triggers snapshot; read gives low half.
  - 5 SNAP_H: read gives high half.
- Reset values:
  - All outputs 0.
  - avm_write_n = 1, avm_chipselect = 0, avm_address = 0, avm_writedata = 0.
  - Internal period register = DEFAULT_PERIOD.
- Bus write: exactly one cycle with chipselect=1, write_n=0, address/writedata stable. Slave has no waitrequest.
- Bus read: drive address (chipselect=0, write_n=1) in cycle N; capture avm_readdata at end of cycle N+1. The address must be held for both cycles.
- Load value: L = period-1. If period==0, L = 0. PERIOD_L receives L[15:0], PERIOD_H receives L[31:16].
- FSM states:
  - IDLE: after reset. Go to CFG_PL if AUTO_CONFIG=1; otherwise wait for cfg_req.
  - CFG_PL: write PERIOD_L, then CFG_PH.
  - CFG_PH: write PERIOD_H, then CFG_CTL.
  - CFG_CTL: write CONTROL=IRQ_ENABLE, set configured=1, then RUN.
  - RUN: one decision per cycle, priority timer_irq > cfg_req > snap_req. Goes to ACK, CFG_PL (latching cfg_period), or SNAP_WR respectively.
  - ACK: write STATUS=0; pulse tick; tick_count+1. Then ACK_WAIT.
  - ACK_WAIT: one idle cycle so the timer_irq deassertion propagates before re-sampling, then RUN.
  - SNAP_WR: write SNAP_L (data 0), then SNAP_RL0.
  - SNAP_RL0: present address 4 (read setup), then SNAP_RL1.
  - SNAP_RL1: present address 4, capture low half, then SNAP_RH0.
  - SNAP_RH0: present address 5 (read setup), then SNAP_RH1.
  - SNAP_RH1: present address 5, capture high half, update snapshot, pulse snapshot_valid, then RUN.
- Request latching:
  - cfg_req or snap_req arriving while not in RUN (or in IDLE) sets a pending flag. The flag is serviced on a later RUN decision.
  - A second pulse of the same request while pending is merged.
  - cfg_period is latched at the pulse; the latest value wins.
- irq during a config or snapshot sequence: the sequence completes uninterrupted, then RUN services the irq. The irq is level, so it is not lost.
- cfg_req in IDLE with AUTO_CONFIG=0 starts CFG_PL directly.
- tick_count is not cleared by reconfiguration; only reset clears it.
- Reset mid-sequence: FSM returns to IDLE and the bus is released immediately (asynchronous). No partial-write recovery is needed because the timer is reset by the same reset_n.
- Latency:
  - irq to tick: 2 cycles (1 to register RUN decision, 1 in ACK).
  - snap_req in RUN to snapshot_valid: 6 cycles.

Decomposition:
- Shared package timer_host_pkg holds:
  - register index constants (STATUS=0 … SNAP_H=5);
  - the state enum;
  - the load-value function (period-1, clamp 0).
- No sub-module is needed. Bus sequencing stays inline in the FSM, and the FSM is kept flat.

Test Plan:
- Auto-config: reset release, AUTO_CONFIG=1 -> writes addr2=0xC34F, addr3=0x0000, addr1=0x0001 on consecutive cycles; configured=1 on the 4th cycle after IDLE.
- Tick service: raise timer_irq; slave model drops it on STATUS write -> exactly one addr0 write, one tick pulse 2 cycles after irq, tick_count=1. Repeat 3x -> tick_count=3.
- Reconfigure: cfg_req with cfg_period=100000 -> PERIOD_L=0x869F, PERIOD_H=0x0001; cfg_period=0 -> both writes 0x0000.
- Snapshot: slave model holds counter 0x0001_2345 -> SNAP_L write, then reads addr4/addr5; snapshot=0x00012345, snapshot_valid 6 cycles after snap_req.
- Priority and collision:
  - irq and snap_req asserted in the same RUN cycle -> ACK first, snapshot follows.
  - snap_req pulsed during CFG_PH -> pending, snapshot executed after CFG_CTL.
  - Asserting reset_n low in SNAP_RL1 -> chipselect=0 and outputs 0 immediately.
- Wrap: preload tick_count=0xFFFFFFFF via force, one irq -> tick_count=0x00000000, tick pulses.
